// File: rtl/conv_encoder.sv
// conv_encoder: rate-1/2 convolutional encoder, constraint length K.
// Converts a framed serial bit stream into 2-bit symbol pairs for the Viterbi decoder path.
//
// Optional feature macro: CONV_ENC_TAIL_EN
//   defined   - each frame is followed by K-1 zero tail bits, so every frame starts and
//               ends in state 0; the last tail pair carries out_last.
//   undefined - no tail; the in_last bit's own pair carries out_last and the shift register
//               is cleared on that handshake.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    input handshake; in_bit is the information bit, in_last ends a frame
//   out_valid/out_ready  output handshake; out_pair[0]/[1] are the G0/G1 parities
//   out_last             marks the final pair of a frame
//   busy                 a tail is in progress or an output pair is held
module conv_encoder #(
  parameter int unsigned  K  = 3,
  parameter logic [K-1:0] G0 = 3'b111,
  parameter logic [K-1:0] G1 = 3'b101
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_bit,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] out_pair,
  output logic       out_last,
  output logic       busy
);

  logic [K-2:0] sr_q, sr_d;
  logic         out_valid_q, out_valid_d;
  logic [1:0]   out_pair_q, out_pair_d;
  logic         out_last_q, out_last_d;

  logic         slot_free;
  logic         load;      // encode one bit and load the output slot this cycle
  logic         enc_bit;   // data bit or tail zero
  logic         last_bit;  // the pair being loaded ends the frame
  logic [K-1:0] v;

  // Slot may be (re)loaded when empty or when its current pair leaves this cycle.
  assign slot_free = !out_valid_q || out_ready;

`ifdef CONV_ENC_TAIL_EN
  typedef enum logic [0:0] {StRun, StTail} state_e;

  localparam logic [2:0] TailLast = 3'(K - 2);

  state_e     state_q, state_d;
  logic [2:0] tail_cnt_q, tail_cnt_d;

  always_comb begin
    state_d    = state_q;
    tail_cnt_d = tail_cnt_q;
    load       = 1'b0;
    enc_bit    = 1'b0;
    last_bit   = 1'b0;
    in_ready   = 1'b0;
    unique case (state_q)
      StRun: begin
        in_ready = !rst && slot_free;
        if (in_valid && in_ready) begin
          load    = 1'b1;
          enc_bit = in_bit;
          if (in_last) begin
            state_d    = StTail;
            tail_cnt_d = '0;
          end
        end
      end
      StTail: begin
        if (slot_free) begin
          load       = 1'b1;
          tail_cnt_d = tail_cnt_q + 3'd1;
          if (tail_cnt_q == TailLast) begin
            last_bit = 1'b1;
            state_d  = StRun;
          end
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StRun;
      tail_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      tail_cnt_q <= tail_cnt_d;
    end
  end

  assign busy = (state_q == StTail) || out_valid_q;
`else
  always_comb begin
    in_ready = !rst && slot_free;
    load     = in_valid && in_ready;
    enc_bit  = in_bit;
    last_bit = in_last;
  end

  assign busy = out_valid_q;
`endif

  always_comb begin
    v           = {enc_bit, sr_q};
    sr_d        = sr_q;
    out_valid_d = out_valid_q && !out_ready;
    out_pair_d  = out_pair_q;
    out_last_d  = out_last_q;
    if (load) begin
      sr_d        = v[K-1:1];
      out_valid_d = 1'b1;
      out_pair_d  = {^(v & G1), ^(v & G0)};
      out_last_d  = last_bit;
`ifndef CONV_ENC_TAIL_EN
      // Without a tail the trellis is not terminated; restart the next frame from state 0.
      if (last_bit) sr_d = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q        <= '0;
      out_valid_q <= 1'b0;
      out_pair_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      sr_q        <= sr_d;
      out_valid_q <= out_valid_d;
      out_pair_q  <= out_pair_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pair  = out_pair_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_conv_encoder.sv
// Self-checking bench for conv_encoder (K=3, G0=111, G1=101); follows CONV_ENC_TAIL_EN.
module tb_conv_encoder;

  localparam int unsigned  K  = 3;
  localparam logic [K-1:0] G0 = 3'b111;
  localparam logic [K-1:0] G1 = 3'b101;
`ifdef CONV_ENC_TAIL_EN
  localparam int TailLen = K - 1;
`else
  localparam int TailLen = 0;
`endif

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       in_bit;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_pair;
  logic       out_last;
  logic       busy;

  conv_encoder #(
    .K (K),
    .G0(G0),
    .G1(G1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_bit   (in_bit),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pair (out_pair),
    .out_last (out_last),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_pass;
  int         n_total;
  int         cyc;
  int         rmode;      // 0: out_ready high, 1: alternate, 2: random
  bit         rnd_in;     // random gaps on in_valid
  bit         stall_prev;
  logic [2:0] held;
  logic [1:0] src_q[$];   // {last, bit}
  logic [2:0] got_q[$];   // {last, pair}
  logic [2:0] exp_q[$];
  int         gcyc_q[$];
  int         hcyc_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: each output is the XOR-convolution of the frame (zero history before it,
  // zero-padded by the tail) with the generator taps; tap K-1-j weights the bit j steps back.
  function automatic void model_frame(input bit bits[$]);
    bit u[$];
    u = bits;
    for (int i = 0; i < TailLen; i++) u.push_back(1'b0);
    for (int i = 0; i < u.size(); i++) begin
      bit p0;
      bit p1;
      p0 = 1'b0;
      p1 = 1'b0;
      for (int j = 0; j < int'(K); j++) begin
        if (i - j >= 0) begin
          p0 = p0 ^ (G0[K-1-j] & u[i-j]);
          p1 = p1 ^ (G1[K-1-j] & u[i-j]);
        end
      end
      exp_q.push_back({(i == u.size() - 1) ? 1'b1 : 1'b0, p1, p0});
    end
  endfunction

  // Expected pairs packed first-pair-in-MSBs; the final one carries out_last.
  task automatic exp_pairs(input logic [31:0] pairs, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({(i == n - 1) ? 1'b1 : 1'b0, pairs[2*(n-1-i) +: 2]});
    end
  endtask

  task automatic add_bits(input logic [31:0] pat, input int n);
    for (int i = 0; i < n; i++) src_q.push_back({(i == n - 1) ? 1'b1 : 1'b0, pat[n-1-i]});
  endtask

  task automatic exp_frame1011();
`ifdef CONV_ENC_TAIL_EN
    exp_pairs(32'b11_01_00_10_10_11, 6);
`else
    exp_pairs(32'b11_01_00_10, 4);
`endif
  endtask

  task automatic exp_single1();
`ifdef CONV_ENC_TAIL_EN
    exp_pairs(32'b11_01_11, 3);
`else
    exp_pairs(32'b11, 1);
`endif
  endtask

  // One clock: sample at negedge, then drive fresh inputs #1 after the rising edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (stall_prev) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_pair", 32'({out_last, out_pair}), 32'(held));
    end
    if (out_valid && !out_ready) begin
      chk("in_ready_stalled", 32'(in_ready), 32'd0);
      stall_prev = 1'b1;
      held       = {out_last, out_pair};
    end else begin
      stall_prev = 1'b0;
    end
    if (out_valid && out_ready) begin
      got_q.push_back({out_last, out_pair});
      gcyc_q.push_back(cyc);
    end
    if (in_valid && in_ready) begin
      void'(src_q.pop_front());
      hcyc_q.push_back(cyc);
    end
    @(posedge clk);
    #1;
    case (rmode)
      0:       out_ready = 1'b1;
      1:       out_ready = !out_ready;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
    in_valid = (src_q.size() != 0) && (!rnd_in || $urandom_range(0, 3) != 0);
    if (src_q.size() != 0) {in_last, in_bit} = src_q[0];
    else {in_last, in_bit} = 2'b00;
  endtask

  task automatic run(input string tag, input int budget);
    int n;
    bit done;
    n    = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      tick();
      n++;
      done = (src_q.size() == 0) && (got_q.size() >= exp_q.size());
    end
    chk({tag, "_in_budget"}, 32'(done), 32'd1);
    tick();
    tick();
  endtask

  task automatic compare(input string tag);
    int m;
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      chk($sformatf("%s_pair%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    end
    got_q.delete();
    exp_q.delete();
    gcyc_q.delete();
    hcyc_q.delete();
  endtask

  task automatic idle_check(input string tag);
    chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
    chk({tag, "_valid_idle"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    bit rb[$];
    bit any_last;
    int exp_n;
    n_pass     = 0;
    n_total    = 0;
    cyc        = 0;
    rmode      = 0;
    rnd_in     = 1'b0;
    stall_prev = 1'b0;
    held       = '0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_bit     = 1'b0;
    in_last    = 1'b0;
    out_ready  = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_pair", 32'(out_pair), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // Frame 1,0,1,1 with out_ready high: latency 1, pairs on consecutive cycles
    add_bits(32'b1011, 4);
    exp_frame1011();
    exp_n = exp_q.size();
    run("f1011", 60);
    chk("f1011_latency",
        (gcyc_q.size() > 0 && hcyc_q.size() > 0) ? 32'(gcyc_q[0] - hcyc_q[0]) : 32'hffff_ffff,
        32'd1);
    chk("f1011_consecutive",
        (gcyc_q.size() > 0) ? 32'(gcyc_q[gcyc_q.size()-1] - gcyc_q[0]) : 32'hffff_ffff,
        32'(exp_n - 1));
    compare("f1011");
    idle_check("f1011");

    // Single-bit frame: must start from state 0
    add_bits(32'b1, 1);
    exp_single1();
    run("single", 40);
    compare("single");
    idle_check("single");

    // Backpressure: out_ready toggles every cycle
    rmode = 1;
    add_bits(32'b1011, 4);
    exp_frame1011();
    run("bp", 80);
    compare("bp");
    idle_check("bp");

    // Back-to-back frames A = 1, B = 1,1
    rmode = 0;
    add_bits(32'b1, 1);
    add_bits(32'b11, 2);
    exp_single1();
`ifdef CONV_ENC_TAIL_EN
    exp_pairs(32'b11_10_10_11, 4);
`else
    exp_pairs(32'b11_10, 2);
`endif
    run("b2b", 60);
    chk("b2b_gap", (hcyc_q.size() > 1) ? 32'(hcyc_q[1] - hcyc_q[0]) : 32'hffff_ffff,
        32'(TailLen + 1));
    compare("b2b");
    idle_check("b2b");

    // Reset in the first cycle after the last bit of a frame is accepted
    add_bits(32'b1011, 4);
    begin
      int n;
      n = 0;
      while (src_q.size() != 0 && n < 50) begin
        tick();
        n++;
      end
      chk("midrst_fed", 32'(src_q.size()), 32'd0);
    end
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    any_last = 1'b0;
    foreach (got_q[i]) any_last = any_last | got_q[i][2];
    chk("midrst_no_last", 32'(any_last), 32'd0);
    got_q.delete();
    gcyc_q.delete();
    hcyc_q.delete();
    src_q.delete();
    stall_prev = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    add_bits(32'b1, 1);
    exp_single1();
    run("after_rst", 40);
    compare("after_rst");

    // Long random frame with random stalls against the reference model
    rmode  = 2;
    rnd_in = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      rb.push_back(1'($urandom_range(0, 1)));
      src_q.push_back({(i == 999) ? 1'b1 : 1'b0, rb[i]});
    end
    model_frame(rb);
    chk("rand_exp_len", 32'(exp_q.size()), 32'(1000 + TailLen));
    run("rand", 20000);
    compare("rand");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
